uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Transmit-side byte queue that sits directly upstream of the UART transmitter in `systemUART`. It buffers bytes written by the host in a small FIFO. It launches each byte into the transmitter with a one-cycle `Tx_WR` pulse, but only when the transmitter is enabled and idle. It then tracks `Tx_BUSY` until the frame completes, so back-to-back bytes go out without host pacing. Overflow and transmitter-no-response conditions are reported through sticky error flags.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `ACK_WAIT`, 16: cycles allowed after a `Tx_WR` pulse for `Tx_BUSY` to rise before the launch is declared failed.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe; one byte per cycle while high.
- `clr_err`  in  1  clears `ovf_err` and `timeout_err`.
- `Tx_EN`  in  1  transmitter enable; also gates launches.
- `Tx_BUSY`  in  1  transmitter busy, from the UART transmitter.
- `Tx_DATA`  out  8  byte presented to the transmitter; registered.
- `Tx_WR`  out  1  one-cycle launch pulse to the transmitter; registered.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  log2(DEPTH)+1  current number of FIFO entries.
- `ovf_err`  out  1  sticky: a write was attempted while full.
- `timeout_err`  out  1  sticky: `Tx_BUSY` did not rise within `ACK_WAIT` cycles of a launch.

## Operation
- **FIFO storage.**
  - Circular buffer with read and write pointers of log2(DEPTH) bits each; pointers wrap from DEPTH-1 to 0.
  - `count` is a separate counter of log2(DEPTH)+1 bits.
  - `full` = (`count`==DEPTH); `empty` = (`count`==0); both are derived from the registered `count`.
- **Push.** When `wr_en`=1 and not `full`: the entry at the write pointer is written with `wr_data`, then the write pointer increments.
- **Overflow.** When `wr_en`=1 and `full`: the data is dropped, `ovf_err` is set, and the pointers and `count` are unchanged.
- **Pop.** A pop occurs only on a launch (see IDLE below).
  - Simultaneous push and pop in one cycle: both happen and `count` is unchanged.
  - A push while `full` in the same cycle as a pop is still treated as overflow, because `full` is evaluated before the edge.
- **State machine.** States are IDLE, WAIT_ACK and WAIT_DONE.
  - **IDLE.** When not `empty`, `Tx_EN`=1 and `Tx_BUSY`=0, the launch happens at the edge:
    - `Tx_DATA` takes the head entry;
    - the read pointer increments;
    - `Tx_WR` goes to 1;
    - the ack counter clears to 0;
    - the next state is WAIT_ACK.
  - **WAIT_ACK.** `Tx_WR` returns to 0.
    - If `Tx_BUSY`=1, go to WAIT_DONE.
    - Otherwise, if the ack counter equals ACK_WAIT-1, set `timeout_err` and go to IDLE. The byte is considered lost and is not re-sent.
    - Otherwise, increment the ack counter.
  - **WAIT_DONE.** If `Tx_BUSY`=0, go to IDLE.
- **Deasserting `Tx_EN`.** It never aborts a frame in flight. It only blocks new launches from IDLE, and the FIFO contents are retained.
- **Error flags.** `clr_err`=1 clears both error flags. If a new error occurs in the same cycle as `clr_err`, the error wins and the flag stays set.
- **`Tx_DATA`.** It holds its value between launches; it changes only on a launch edge.

## Timing
- **Reset values** (while `reset`=0 at an edge):
  - state IDLE; both pointers 0; `count` 0; `empty`=1; `full`=0;
  - `Tx_WR`=0; `Tx_DATA`=8'h00; `ovf_err`=0; `timeout_err`=0.
  - FIFO storage contents are don't-care.
- **Reset mid-operation.** Reset in any state drops the queued bytes and returns the block to the reset values on the next edge. The block does not wait for `Tx_BUSY`.
- **Push visibility.** A push at edge N is visible on `count` and `empty` after edge N.
- **Write-to-launch latency.** With the FIFO empty, `Tx_EN`=1 and `Tx_BUSY`=0, a write at edge N gives `Tx_WR`=1 during cycle N+1 to N+2. That is 1 cycle from write to launch.
- **Pulse width.** `Tx_WR` is high for exactly one clock per launch.
- **Back-to-back bytes.** The earliest next launch is one IDLE cycle after `Tx_BUSY` is seen low in WAIT_DONE. The minimum launch spacing is frame length + 2 cycles.
- **Error-flag timing.**
  - `timeout_err` asserts at the edge ending the ACK_WAIT-th cycle of WAIT_ACK.
  - `ovf_err` asserts at the edge of the offending write.

## Test plan
- **Single byte.** Reset low for 5 cycles, then high.
  - Write 8'hAA with `Tx_EN`=1 and `Tx_BUSY` modelled by the UART transmitter.
  - Expect one `Tx_WR` pulse with `Tx_DATA`=8'hAA one cycle after the write, `empty`=1 after the pop, and no further pulses.
- **Burst ordering.** Write 8'hAA, 8'h55, 8'hCC, 8'h89 on consecutive cycles.
  - Expect `count` to peak at 3 or 4.
  - Expect four `Tx_WR` pulses in that order, each issued only after `Tx_BUSY` has fallen, and never two pulses within one frame.
- **Fill and overflow.** Hold `Tx_EN`=0 and write DEPTH+1 bytes (0x00..0x08).
  - Expect `full`=1, `count`=8 and `ovf_err`=1.
  - Raise `Tx_EN` and expect 0x00..0x07 to be launched, with 0x08 absent.
  - Pulse `clr_err` and expect `ovf_err`=0.
- **Timeout.** Tie `Tx_BUSY`=0 and write 8'h3C.
  - Expect one `Tx_WR` pulse, then `timeout_err`=1 exactly 16 cycles later, with the state back in IDLE.
  - A following write of 8'h3D must still launch.
- **Enable and wrap.**
  - Drop `Tx_EN` during a frame: the frame completes, no new launch happens while `Tx_EN`=0, and launches resume when it returns to 1.
  - Push and pop 20 bytes continuously: pointers wrap and the data order is preserved.
- **Reset and simultaneous events.**
  - Assert reset in WAIT_DONE with 3 bytes queued: next cycle `count`=0, `Tx_WR`=0, `Tx_DATA`=0.
  - Push on the same cycle as a launch with `count`=2: `count` stays 2.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Transmit byte queue feeding the UART transmitter: buffers host bytes, launches one
// per frame with a single-cycle Tx_WR pulse, and reports overflow / no-response errors.
module uart_tx_feeder #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ACK_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  input  logic                   clr_err,
  input  logic                   Tx_EN,
  input  logic                   Tx_BUSY,
  output logic [7:0]             Tx_DATA,
  output logic                   Tx_WR,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err,
  output logic                   timeout_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACK_W-1:0]   ack_q, ack_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_wr_q, tx_wr_d;
  logic               ovf_q, ovf_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];

  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               launch_c;
  logic               timeout_set_c;

  // Flags come from the registered count, so a push while full is overflow even if
  // a pop happens on the same edge.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == CNT_W'(0));
  assign push_c  = wr_en & ~full_c;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ack_d         = ack_q;
    tx_data_d     = tx_data_q;
    tx_wr_d       = 1'b0;
    launch_c      = 1'b0;
    timeout_set_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty_c && Tx_EN && !Tx_BUSY) begin
          launch_c  = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          tx_wr_d   = 1'b1;
          ack_d     = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else if (ack_q == ACK_W'(ACK_WAIT - 1)) begin
          // Byte is abandoned; it is not re-sent.
          timeout_set_c = 1'b1;
          state_d       = IDLE;
        end else begin
          ack_d = ack_q + ACK_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(launch_c);

    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d     = (ovf_q & ~clr_err) | (wr_en & full_c);
    timeout_d = (timeout_q & ~clr_err) | timeout_set_c;
  end

  always_comb begin
    mem_d = mem_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_q     <= '0;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign Tx_DATA     = tx_data_q;
  assign Tx_WR       = tx_wr_q;
  assign full        = full_c;
  assign empty       = empty_c;
  assign count       = count_q;
  assign ovf_err     = ovf_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model checked every cycle, a
// vector table for fill/overflow, directed corner sequences and a random phase.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned ACK_WAIT = 16;

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       clr_err;
  logic       Tx_EN;
  logic       Tx_BUSY;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf_err;
  logic       timeout_err;

  uart_tx_feeder #(.DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .clr_err(clr_err),
    .Tx_EN(Tx_EN), .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR),
    .full(full), .empty(empty), .count(count), .ovf_err(ovf_err),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a queue of pending bytes plus an "in flight" launch record.
  logic [7:0] mq[$];
  bit         m_inflight, m_acked, m_wr, m_ovf, m_to;
  int         m_age;
  logic [7:0] m_data;

  // Transmitter model driving Tx_BUSY.
  bit tx_auto;
  int tx_frame, tx_dmax, tx_pend, tx_left;

  logic [7:0] launched[$];
  int         peak;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit launch, push, ovf_set, to_set;
    if (!reset) begin
      mq.delete();
      m_inflight = 0; m_acked = 0; m_age = 0; m_wr = 0; m_data = 8'h00;
      m_ovf = 0; m_to = 0;
      return;
    end
    launch  = !m_inflight && (mq.size() > 0) && Tx_EN && !Tx_BUSY;
    push    = wr_en && (mq.size() < DEPTH);
    ovf_set = wr_en && (mq.size() == DEPTH);
    to_set  = 0;
    if (m_inflight) begin
      if (!m_acked) begin
        if (Tx_BUSY) m_acked = 1;
        else if (m_age == int'(ACK_WAIT) - 1) begin
          m_inflight = 0;
          to_set = 1;
        end else m_age++;
      end else if (!Tx_BUSY) begin
        m_inflight = 0;
      end
    end
    m_wr = launch;
    if (launch) begin
      m_data = mq.pop_front();
      m_inflight = 1; m_acked = 0; m_age = 0;
    end
    if (push) mq.push_back(wr_data);
    m_ovf = (m_ovf && !clr_err) || ovf_set;
    m_to  = (m_to && !clr_err) || to_set;
  endtask

  // One clock: model the edge, check all outputs, update transmitter, clear pulses.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("tx_wr", 32'(Tx_WR), 32'(m_wr));
    chk("tx_data", 32'(Tx_DATA), 32'(m_data));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    if (Tx_WR === 1'b1) launched.push_back(Tx_DATA);
    if (int'(count) > peak) peak = int'(count);
    if (tx_auto) begin
      if (Tx_BUSY) begin
        tx_left--;
        if (tx_left <= 0) Tx_BUSY = 1'b0;
      end
      if (Tx_WR === 1'b1) tx_pend = $urandom_range(tx_dmax, 0);
      if (tx_pend == 0) begin
        Tx_BUSY = 1'b1;
        tx_left = tx_frame;
        tx_pend = -1;
      end else if (tx_pend > 0) begin
        tx_pend--;
      end
    end
    wr_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] burst[4];
    int sent;
    burst[0] = 8'hAA; burst[1] = 8'h55; burst[2] = 8'hCC; burst[3] = 8'h89;
    for (int i = 0; i < 13; i++) begin
      vecs[i].wr = 1'b1; vecs[i].data = 8'(i); vecs[i].clr = 1'b0;
      vecs[i].exp_count = (i < 8) ? i + 1 : 8;
      vecs[i].exp_full = (i >= 7);
      vecs[i].exp_ovf = (i >= 8);
    end
    vecs[9].clr  = 1'b1;                     // clear loses to a same-cycle overflow
    vecs[10].wr  = 1'b0; vecs[10].clr = 1'b1; vecs[10].exp_ovf = 1'b0;
    vecs[11].data = 8'h0A;
    vecs[12].wr  = 1'b0; vecs[12].clr = 1'b1; vecs[12].exp_ovf = 1'b0;

    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
    Tx_EN = 1'b1; Tx_BUSY = 1'b0;
    tx_auto = 1; tx_frame = 4; tx_dmax = 0; tx_pend = -1; tx_left = 0; peak = 0;

    // Reset values
    run(5);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_tx_wr", 32'(Tx_WR), 32'd0);
    chk("rst_tx_data", 32'(Tx_DATA), 32'h00);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    step();

    // Single byte: one-cycle write-to-launch latency
    launched.delete();
    write_byte(8'hAA);
    chk("sb_count_after_push", 32'(count), 32'd1);
    chk("sb_no_launch_yet", 32'(Tx_WR), 32'd0);
    step();
    chk("sb_tx_wr", 32'(Tx_WR), 32'd1);
    chk("sb_tx_data", 32'(Tx_DATA), 32'hAA);
    chk("sb_empty", 32'(empty), 32'd1);
    step();
    chk("sb_pulse_width", 32'(Tx_WR), 32'd0);
    run(20);
    chk("sb_pulses", 32'(launched.size()), 32'd1);

    // Burst ordering
    launched.delete(); peak = 0;
    for (int i = 0; i < 4; i++) write_byte(burst[i]);
    run(40);
    chk("burst_peak", 32'(peak == 3 || peak == 4), 32'd1);
    chk("burst_n", 32'(launched.size()), 32'd4);
    for (int i = 0; i < 4 && i < launched.size(); i++)
      chk("burst_order", 32'(launched[i]), 32'(burst[i]));

    // Fill and overflow with the transmitter disabled
    launched.delete();
    Tx_EN = 1'b0;
    for (int i = 0; i < 13; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].data; clr_err = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'd0);
      chk($sformatf("vec%0d_ovf", i), 32'(ovf_err), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_no_launch", i), 32'(Tx_WR), 32'd0);
    end
    Tx_EN = 1'b1;
    run(80);
    chk("fill_n", 32'(launched.size()), 32'd8);
    for (int i = 0; i < 8 && i < launched.size(); i++)
      chk("fill_order", 32'(launched[i]), 32'(i));
    clr_err = 1'b1;
    step();
    chk("fill_ovf_cleared", 32'(ovf_err), 32'd0);

    // Timeout: transmitter never responds
    tx_auto = 0; tx_pend = -1; Tx_BUSY = 1'b0;
    launched.delete();
    write_byte(8'h3C);
    step();
    chk("to_tx_wr", 32'(Tx_WR), 32'd1);
    chk("to_tx_data", 32'(Tx_DATA), 32'h3C);
    run(15);
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    step();
    chk("to_set_at_16", 32'(timeout_err), 32'd1);
    write_byte(8'h3D);
    step();
    chk("to_relaunch_wr", 32'(Tx_WR), 32'd1);
    chk("to_relaunch_data", 32'(Tx_DATA), 32'h3D);
    run(20);
    clr_err = 1'b1;
    step();
    chk("to_cleared", 32'(timeout_err), 32'd0);

    // Dropping Tx_EN mid-frame blocks only new launches
    tx_auto = 1; tx_frame = 8; tx_dmax = 0; tx_pend = -1;
    launched.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    Tx_EN = 1'b0;
    run(20);
    chk("en_hold_n", 32'(launched.size()), 32'd1);
    chk("en_hold_count", 32'(count), 32'd1);
    Tx_EN = 1'b1;
    for (int i = 0; i < 10 && launched.size() < 2; i++) step();
    chk("en_resume_n", 32'(launched.size()), 32'd2);
    if (launched.size() >= 2) chk("en_resume_data", 32'(launched[1]), 32'h22);
    run(15);

    // Continuous stream of 20 bytes: pointers wrap, order kept
    tx_frame = 1;
    launched.delete(); sent = 0;
    for (int i = 0; i < 400 && launched.size() < 20; i++) begin
      if (sent < 20 && full === 1'b0) begin
        wr_en = 1'b1; wr_data = 8'(8'h40 + sent); sent++;
      end
      step();
    end
    chk("wrap_n", 32'(launched.size()), 32'd20);
    for (int i = 0; i < 20 && i < launched.size(); i++)
      chk("wrap_order", 32'(launched[i]), 32'(8'h40 + i));
    run(5);

    // Reset while waiting for frame completion with 3 bytes queued
    tx_frame = 30;
    for (int i = 0; i < 4; i++) write_byte(8'(8'hA0 + i));
    run(2);
    chk("rstmid_pre_count", 32'(count), 32'd3);
    reset = 1'b0;
    step();
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_tx_wr", 32'(Tx_WR), 32'd0);
    chk("rstmid_tx_data", 32'(Tx_DATA), 32'h00);
    chk("rstmid_empty", 32'(empty), 32'd1);
    reset = 1'b1;
    run(40);

    // Push on the same cycle as a launch with count=2
    tx_frame = 3;
    launched.delete();
    Tx_EN = 1'b0;
    write_byte(8'hB0);
    write_byte(8'hB1);
    Tx_EN = 1'b1;
    write_byte(8'hB2);
    chk("simul_tx_wr", 32'(Tx_WR), 32'd1);
    chk("simul_count", 32'(count), 32'd2);
    run(40);
    chk("simul_n", 32'(launched.size()), 32'd3);
    for (int i = 0; i < 3 && i < launched.size(); i++)
      chk("simul_order", 32'(launched[i]), 32'(8'hB0 + i));

    // Random traffic against the model
    tx_dmax = 2;
    for (int i = 0; i < 700; i++) begin
      if (i == 300) begin tx_auto = 0; tx_pend = -1; Tx_BUSY = 1'b0; end
      if (i == 420) tx_auto = 1;
      tx_frame = $urandom_range(6, 1);
      wr_en    = ($urandom_range(99, 0) < 35);
      wr_data  = 8'($urandom);
      clr_err  = ($urandom_range(99, 0) < 3);
      if ($urandom_range(99, 0) < 5) Tx_EN = ~Tx_EN;
      step();
    end
    Tx_EN = 1'b1;
    run(120);
    chk("final_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
